// File: rtl/lr1_preimage_search.sv
// ============================================================================
// Module   : lr1_preimage_search
// Purpose  : Finds every 4-bit preimage X of a target Y under a fixed,
//            non-bijective 4-bit substitution F. After START is accepted the
//            block scans all 16 candidates in ascending order, one per cycle.
//            It pulses X_VALID for each match and pulses DONE exactly 16
//            cycles after acceptance.
// Ports    : CLK      - clock, rising edge
//            RST      - asynchronous active-high reset
//            START    - search request (ignored while BUSY)
//            Y        - target value, latched when START is accepted
//            BUSY     - search in progress
//            X        - most recently found preimage
//            X_VALID  - one-cycle pulse per preimage found
//            COUNT    - preimages found in the current/last search (0..16)
//            FOUND    - last search found at least one preimage
//            DONE     - one-cycle pulse at end of search
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr1_preimage_search (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] Y,
  output logic       BUSY,
  output logic [3:0] X,
  output logic       X_VALID,
  output logic [4:0] COUNT,
  output logic       FOUND,
  output logic       DONE
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Forward substitution F, indexed by the candidate value.
  function automatic logic [3:0] sbox(input logic [3:0] v);
    case (v)
      4'h0: sbox = 4'hA;  4'h1: sbox = 4'h7;  4'h2: sbox = 4'h1;  4'h3: sbox = 4'hD;
      4'h4: sbox = 4'h3;  4'h5: sbox = 4'h7;  4'h6: sbox = 4'hC;  4'h7: sbox = 4'h3;
      4'h8: sbox = 4'h5;  4'h9: sbox = 4'hB;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h5;
      4'hC: sbox = 4'h9;  4'hD: sbox = 4'h8;  4'hE: sbox = 4'hE;  default: sbox = 4'h7;
    endcase
  endfunction

  state_t     state, state_nx;
  logic [3:0] target, target_nx;
  logic [3:0] cand, cand_nx;
  logic [3:0] x_nx;
  logic       x_valid_nx;
  logic [4:0] count_nx;
  logic       found_nx;
  logic       busy_nx;
  logic       done_nx;
  logic       hit;
  logic [4:0] count_inc;

  // Candidate comparison and the count value including this candidate's hit.
  assign hit       = (sbox(cand) == target);
  assign count_inc = COUNT + {4'd0, hit};

  always_comb begin
    // Everything holds by default; the two pulses fall back to zero.
    state_nx   = state;
    target_nx  = target;
    cand_nx    = cand;
    x_nx       = X;
    x_valid_nx = 1'b0;
    count_nx   = COUNT;
    found_nx   = FOUND;
    busy_nx    = BUSY;
    done_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          target_nx = Y;
          cand_nx   = 4'd0;
          count_nx  = 5'd0;
          found_nx  = 1'b0;
          busy_nx   = 1'b1;
          state_nx  = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          x_nx       = cand;
          x_valid_nx = 1'b1;
          count_nx   = count_inc;
        end
        // Candidate 15 is always the last one; the counter never wraps,
        // so every search takes exactly 16 cycles.
        if (cand == 4'hF) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          found_nx = (count_inc != 5'd0);
        end else begin
          cand_nx = cand + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      target  <= 4'd0;
      cand    <= 4'd0;
      X       <= 4'd0;
      X_VALID <= 1'b0;
      COUNT   <= 5'd0;
      FOUND   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nx;
      target  <= target_nx;
      cand    <= cand_nx;
      X       <= x_nx;
      X_VALID <= x_valid_nx;
      COUNT   <= count_nx;
      FOUND   <= found_nx;
      BUSY    <= busy_nx;
      DONE    <= done_nx;
    end
  end

endmodule

`default_nettype wire

// File: doc/lr1_preimage_search.md
LR1_PREIMAGE_SEARCH -- requirements
Module: lr1_preimage_search

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  request strobe; sampled on rising CLK.
REQ-005 Y  input  4  target substitution value; sampled only when START is accepted.
REQ-006 BUSY  output  1  high while a search is in progress.
REQ-007 X  output  4  most recently found preimage.
REQ-008 X_VALID  output  1  one-cycle pulse per preimage found.
REQ-009 COUNT  output  5  number of preimages found in the current or last search (0..16).
REQ-010 FOUND  output  1  COUNT != 0 at end of last search.
REQ-011 DONE  output  1  one-cycle pulse at end of search.

Function
REQ-012 The block SHALL embed the forward 4-bit substitution F as a constant table.
- F: 0->A, 1->7, 2->1, 3->D, 4->3, 5->7, 6->C, 7->3.
- F: 8->5, 9->B, A->F, B->5, C->9, D->8, E->E, F->7.
REQ-013 The block SHALL find every X with F(X)==Y, because F is not bijective: 7 has 3 preimages, 3 and 5 have 2 each, and 0, 2, 4, 6 have none.
REQ-014 The FSM SHALL have exactly two states, IDLE and SCAN, and all outputs SHALL be registered.
REQ-015 In IDLE with START=1 at edge E0, the block SHALL:
- latch Y into an internal target register;
- set candidate=0 and COUNT=0, and clear FOUND;
- set BUSY=1 and enter SCAN.
REQ-016 In SCAN, at edges E1..E16 the block SHALL evaluate candidates 0..15 in ascending order, one per edge.
REQ-017 On a match at edge Ek, the block SHALL set X=k-1, set X_VALID=1 for exactly the following cycle, and increment COUNT at the same edge.
REQ-018 On a non-match, X_VALID SHALL be 0 and X SHALL hold its previous value.
REQ-019 At edge E16, after evaluating candidate F, the block SHALL:
- enter IDLE;
- set BUSY=0 and DONE=1 for one cycle;
- set FOUND=(final COUNT != 0).
REQ-020 The candidate counter SHALL NOT wrap; reaching 15 SHALL always terminate the search.
REQ-021 Total latency SHALL be fixed at 16 cycles from START acceptance to DONE, independent of Y.
REQ-022 START while BUSY=1 SHALL be ignored and SHALL NOT restart or extend the search.
REQ-023 Changes on Y after acceptance SHALL NOT affect the running search.
REQ-024 START in the cycle where DONE=1 SHALL be accepted, because the state is then IDLE; the new search SHALL begin normally.
REQ-025 COUNT, FOUND and X SHALL hold their values after DONE until the next accepted START.

Reset
REQ-026 RST=1 SHALL immediately, without waiting for CLK, force state=IDLE and BUSY=0.
REQ-027 RST=1 SHALL immediately force X=0, X_VALID=0, COUNT=0, FOUND=0, DONE=0, and zero the target and candidate registers.
REQ-028 Reset during SCAN SHALL abort the search with no DONE pulse.
REQ-029 The first START after RST deasserts SHALL be accepted normally.

Verification
REQ-030 Y=7 -> X_VALID pulses after E2 (X=1), E6 (X=5) and E16 (X=F); DONE after E16; COUNT=3; FOUND=1.
REQ-031 Y=0 -> no X_VALID pulse; DONE after E16; COUNT=0; FOUND=0.
REQ-032 Y=A -> single X_VALID after E1 with X=0; COUNT=1; FOUND=1.
REQ-033 Y=5, then change Y to 7 and pulse START at E5 -> ignored; X=8 and X=B only; COUNT=2; DONE after E16.
REQ-034 Y=7, RST pulsed between E8 and E9 -> all outputs 0 asynchronously and no DONE; new START with Y=3 -> X=4, X=7; COUNT=2.
REQ-035 START with Y=E asserted during a DONE cycle -> accepted; one match X=E after E15; DONE 16 cycles later; COUNT=1.
